// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, parity encodings and frame-format constants
// used by both the receive and transmit sides.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP1,
        ST_STOP2
    } uart_state_e;

    typedef enum logic [1:0] {
        PAR_NONE0 = 2'b00,
        PAR_ODD   = 2'b01,
        PAR_EVEN  = 2'b10,
        PAR_NONE3 = 2'b11
    } parity_e;

    localparam logic LEN_7BIT = 1'b0;
    localparam logic LEN_8BIT = 1'b1;
    localparam logic STOP_ONE = 1'b0;
    localparam logic STOP_TWO = 1'b1;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-stage synchronizer for an asynchronous single-bit input; all stages reset to 1
// so an idle serial line never looks like a falling edge out of reset.
module sync_ff #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/sipo_rx.sv
// Oversampling UART receiver: 7/8 data bits, optional odd/even parity, 1 or 2 stop bits.
// Define SIPO_RX_MAJORITY_EN to take every data/parity/stop sample as a 2-of-3 vote.
module sipo_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_tick,
    input  logic       data_in,
    input  logic [1:0] parity_type,
    input  logic       stop_bits,
    input  logic       data_length,
    input  logic       rx_read,
    output logic [7:0] data_out,
    output logic       rx_valid,
    output logic       parity_error,
    output logic       framing_error,
    output logic       overrun_error,
    output logic       rx_active
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] CNT_LAST  = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] CNT_START = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] CNT_SMP   = CW'(OVERSAMPLE / 2);

    logic rxd;
    logic prev_s;
    logic smp;

    sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk_i(clk),
        .rst_i(rst),
        .d_i  (data_in),
        .q_o  (rxd)
    );

    // Sample decisions are taken one tick after the mid-bit tick in both builds so
    // the majority vote can include the tick after mid-bit without changing latency.
`ifdef SIPO_RX_MAJORITY_EN
    logic [1:0] hist_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= 2'b11;
        end else if (baud_tick) begin
            hist_q <= {hist_q[0], rxd};
        end
    end

    assign smp    = maj3(hist_q[1], hist_q[0], rxd);
    assign prev_s = hist_q[0];
`else
    logic hist_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= 1'b1;
        end else if (baud_tick) begin
            hist_q <= rxd;
        end
    end

    assign smp    = hist_q;
    assign prev_s = hist_q;
`endif

    uart_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    parity_e       par_q, par_d;
    logic          stop_q, stop_d;
    logic          len_q, len_d;
    logic          pe_q, pe_d;
    logic          fe_q, fe_d;
    logic          done;

    logic [7:0]    dout_q;
    logic          valid_q, perr_q, ferr_q, ovr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            par_q   <= PAR_NONE0;
            stop_q  <= STOP_ONE;
            len_q   <= LEN_8BIT;
            pe_q    <= 1'b0;
            fe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            par_q   <= par_d;
            stop_q  <= stop_d;
            len_q   <= len_d;
            pe_q    <= pe_d;
            fe_q    <= fe_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        par_d   = par_q;
        stop_d  = stop_q;
        len_d   = len_q;
        pe_d    = pe_q;
        fe_d    = fe_q;
        done    = 1'b0;

        if (baud_tick) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
            unique case (state_q)
                ST_IDLE: begin
                    cnt_d = '0;
                    if (prev_s && !rxd) begin
                        state_d = ST_START;
                        par_d   = parity_e'(parity_type);
                        stop_d  = stop_bits;
                        len_d   = data_length;
                        bit_d   = '0;
                        sh_d    = '0;
                        pe_d    = 1'b0;
                        fe_d    = 1'b0;
                    end
                end
                ST_START: begin
                    if (cnt_q == CNT_START && rxd) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (cnt_q == CNT_SMP) begin
                        sh_d = {smp, sh_q[7:1]};
                    end
                    if (cnt_q == CNT_LAST) begin
                        bit_d = bit_q + 3'd1;
                        if (bit_q == ((len_q == LEN_8BIT) ? 3'd7 : 3'd6)) begin
                            state_d = (par_q == PAR_ODD || par_q == PAR_EVEN) ? ST_PARITY : ST_STOP1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (cnt_q == CNT_SMP) begin
                        pe_d = ((^sh_q) ^ smp) != (par_q == PAR_ODD);
                    end
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_STOP1;
                    end
                end
                ST_STOP1: begin
                    if (cnt_q == CNT_SMP) begin
                        fe_d = fe_q | ~smp;
                        if (stop_q != STOP_TWO) begin
                            done    = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end
                    if (cnt_q == CNT_LAST && stop_q == STOP_TWO) begin
                        state_d = ST_STOP2;
                    end
                end
                ST_STOP2: begin
                    if (cnt_q == CNT_SMP) begin
                        fe_d    = fe_q | ~smp;
                        done    = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // A completing frame always wins over rx_read; overrun only when the old frame was unread.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else if (done) begin
            dout_q  <= (len_q == LEN_8BIT) ? sh_q : {1'b0, sh_q[7:1]};
            perr_q  <= pe_q;
            ferr_q  <= fe_d;
            valid_q <= 1'b1;
            ovr_q   <= valid_q & ~rx_read;
        end else if (rx_read && valid_q) begin
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end
    end

    assign data_out      = dout_q;
    assign rx_valid      = valid_q;
    assign parity_error  = perr_q;
    assign framing_error = ferr_q;
    assign overrun_error = ovr_q;
    assign rx_active     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sipo_rx.sv
// Scoreboard bench for sipo_rx: frames are driven bit-by-bit, expected results are
// queued from a frame-level model and checked by an independent monitor.
module tb_sipo_rx;

    localparam int OS = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       baud_tick = 1'b0;
    logic       data_in = 1'b1;
    logic [1:0] parity_type = 2'b00;
    logic       stop_bits = 1'b0;
    logic       data_length = 1'b1;
    logic       drv_read = 1'b0;
    logic       mon_ack = 1'b0;
    logic       rx_read;
    logic [7:0] data_out;
    logic       rx_valid, parity_error, framing_error, overrun_error, rx_active;

    assign rx_read = drv_read | mon_ack;

    sipo_rx #(.OVERSAMPLE(OS), .SYNC_STAGES(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .baud_tick    (baud_tick),
        .data_in      (data_in),
        .parity_type  (parity_type),
        .stop_bits    (stop_bits),
        .data_length  (data_length),
        .rx_read      (rx_read),
        .data_out     (data_out),
        .rx_valid     (rx_valid),
        .parity_error (parity_error),
        .framing_error(framing_error),
        .overrun_error(overrun_error),
        .rx_active    (rx_active)
    );

    always #5 clk = ~clk;

    logic [1:0] div = 2'd0;
    always @(posedge clk) begin
        div       <= div + 2'd1;
        baud_tick <= (div == 2'd3);
    end

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   total = 0;
    int   bad = 0;
    bit   auto_ack = 1'b1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Frame-level reference: what a receiver must report for the bits put on the line.
    function automatic exp_t model(input logic [7:0] d, input bit len8, input logic [1:0] pt,
                                   input bit stop2, input logic pbit, input logic s1, input logic s2);
        exp_t r;
        logic [7:0] dm;
        int ones;
        dm   = len8 ? d : (d & 8'h7F);
        ones = $countones(dm) + int'(pbit);
        r.d  = dm;
        if (pt == 2'b01)      r.pe = (ones % 2) != 1;
        else if (pt == 2'b10) r.pe = (ones % 2) != 0;
        else                  r.pe = 1'b0;
        r.fe = !s1 || (stop2 && !s2);
        return r;
    endfunction

    function automatic logic good_par(input logic [7:0] d, input bit len8, input logic [1:0] pt);
        int ones;
        ones = $countones(len8 ? d : (d & 8'h7F));
        return (pt == 2'b01) ? logic'((ones % 2) == 0) : logic'((ones % 2) == 1);
    endfunction

    task automatic wait_tick();
        @(posedge clk);
        while (!baud_tick) @(posedge clk);
        #1;
    endtask

    task automatic hold(input logic b, input int n);
        data_in = b;
        repeat (n) wait_tick();
    endtask

    task automatic send(input logic [7:0] d, input bit len8, input logic [1:0] pt, input bit stop2,
                        input logic pbit, input logic s1, input logic s2, input bit scramble);
        parity_type = pt;
        stop_bits   = stop2;
        data_length = len8;
        hold(1'b0, 4);
        if (scramble) begin
            parity_type = 2'($urandom);
            stop_bits   = 1'($urandom);
            data_length = 1'($urandom);
        end
        hold(1'b0, OS - 4);
        for (int i = 0; i < (len8 ? 8 : 7); i++) hold(d[i], OS);
        if (pt == 2'b01 || pt == 2'b10) hold(pbit, OS);
        hold(s1, OS);
        if (stop2) hold(s2, OS);
    endtask

    task automatic queue_send(input logic [7:0] d, input bit len8, input logic [1:0] pt, input bit stop2,
                              input logic pbit, input logic s1, input logic s2, input bit scramble);
        q.push_back(model(d, len8, pt, stop2, pbit, s1, s2));
        send(d, len8, pt, stop2, pbit, s1, s2, scramble);
    endtask

    task automatic pulse_read();
        @(negedge clk);
        drv_read = 1'b1;
        @(negedge clk);
        drv_read = 1'b0;
    endtask

    // Monitor: every rising rx_valid must match the oldest queued frame.
    logic vprev = 1'b0;
    bit   ack_pend = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            vprev    = 1'b0;
            ack_pend = 1'b0;
            mon_ack  = 1'b0;
        end else begin
            if (ack_pend) begin
                mon_ack  = 1'b0;
                ack_pend = 1'b0;
                check("ack_valid", 32'(rx_valid), 32'd0);
                check("ack_overrun", 32'(overrun_error), 32'd0);
            end else if (rx_valid && !vprev) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_frame got=%0h exp=none", data_out);
                end else begin
                    e = q.pop_front();
                    check("data_out", 32'(data_out), 32'(e.d));
                    check("parity_error", 32'(parity_error), 32'(e.pe));
                    check("framing_error", 32'(framing_error), 32'(e.fe));
                    check("overrun_on_rise", 32'(overrun_error), 32'd0);
                    check("active_after_done", 32'(rx_active), 32'd0);
                end
                if (auto_ack) begin
                    mon_ack  = 1'b1;
                    ack_pend = 1'b1;
                end
            end
            vprev = rx_valid;
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] d;
        bit         len8, stop2;
        logic [1:0] pt;
        logic       pb, s1, s2;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_data", 32'(data_out), 32'd0);
        check("rst_valid", 32'(rx_valid), 32'd0);
        check("rst_flags", {29'd0, parity_error, framing_error, overrun_error}, 32'd0);
        check("rst_active", 32'(rx_active), 32'd0);
        rst = 1'b0;
        hold(1'b1, 10);

        // 8N1 0xA5, held until read
        auto_ack = 1'b0;
        queue_send(8'hA5, 1, 2'b00, 0, 1'b0, 1'b1, 1'b1, 0);
        repeat (50) @(negedge clk);
        check("valid_held", 32'(rx_valid), 32'd1);
        pulse_read();
        check("read_clears", 32'(rx_valid), 32'd0);
        auto_ack = 1'b1;
        hold(1'b1, 6);

        // 7-bit odd parity, 2 stop, parity bit 0 then 1
        queue_send(8'h41, 0, 2'b01, 1, 1'b0, 1'b1, 1'b1, 0);
        hold(1'b1, 6);
        queue_send(8'h41, 0, 2'b01, 1, 1'b1, 1'b1, 1'b1, 0);
        hold(1'b1, 6);

        // Glitch shorter than half a bit
        hold(1'b0, 4);
        check("glitch_active", 32'(rx_active), 32'd1);
        hold(1'b1, OS);
        check("glitch_reject", 32'(rx_active), 32'd0);
        hold(1'b1, 6);

        // Overrun: two frames, no read
        auto_ack = 1'b0;
        queue_send(8'h11, 1, 2'b00, 0, 1'b0, 1'b1, 1'b1, 0);
        hold(1'b1, 6);
        send(8'h22, 1, 2'b00, 0, 1'b0, 1'b1, 1'b1, 0);
        hold(1'b1, 2);
        check("ovr_data", 32'(data_out), 32'h22);
        check("ovr_flag", 32'(overrun_error), 32'd1);
        check("ovr_valid", 32'(rx_valid), 32'd1);
        pulse_read();
        check("ovr_read_valid", 32'(rx_valid), 32'd0);
        check("ovr_read_flag", 32'(overrun_error), 32'd0);
        pulse_read();
        check("idle_read_data", 32'(data_out), 32'h22);
        check("idle_read_valid", 32'(rx_valid), 32'd0);
        auto_ack = 1'b1;
        hold(1'b1, 6);

        // Reset during data bit 4
        parity_type = 2'b00; stop_bits = 1'b0; data_length = 1'b1;
        hold(1'b0, OS);
        d = 8'hC3;
        for (int i = 0; i < 4; i++) hold(d[i], OS);
        hold(d[4], OS / 2);
        @(negedge clk);
        rst = 1'b1;
        data_in = 1'b1;
        #1;
        check("mid_rst_data", 32'(data_out), 32'd0);
        check("mid_rst_valid", 32'(rx_valid), 32'd0);
        check("mid_rst_active", 32'(rx_active), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        hold(1'b1, OS);
        queue_send(8'h7E, 1, 2'b00, 0, 1'b0, 1'b1, 1'b1, 0);
        hold(1'b1, 6);

        // Framing error, then a long break
        queue_send(8'h3C, 1, 2'b00, 0, 1'b0, 1'b0, 1'b1, 0);
        hold(1'b1, 6);
        q.push_back(model(8'h00, 1, 2'b00, 0, 1'b0, 1'b0, 1'b0));
        parity_type = 2'b00; stop_bits = 1'b0; data_length = 1'b1;
        hold(1'b0, 15 * OS);
        check("break_idle", 32'(rx_active), 32'd0);
        hold(1'b0, 5 * OS);
        check("break_no_rearm", 32'(rx_active), 32'd0);
        hold(1'b1, 2 * OS);

        // Randomized frames with config changes mid-frame
        for (int n = 0; n < 18; n++) begin
            d     = 8'($urandom);
            len8  = 1'($urandom);
            pt    = 2'($urandom);
            stop2 = 1'($urandom);
            pb    = good_par(d, len8, pt) ^ (($urandom % 4) == 0);
            s1    = ($urandom % 5) != 0;
            s2    = ($urandom % 5) != 0;
            queue_send(d, len8, pt, stop2, pb, s1, s2, 1);
            hold(1'b1, $urandom_range(2, 20));
        end

        hold(1'b1, 8);
        check("queue_drained", 32'(q.size()), 32'd0);
        check("final_active", 32'(rx_active), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
